// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch front end feeding the IF/ID register.
// Issues word-aligned requests over a req/ack handshake and holds the
// returned instruction in a one-entry buffer. The buffer is released by a
// downstream consume (valid and no hazard). A flush redirects the fetch PC
// and discards the buffered instruction and any in-flight instruction.
// Optional build macro FETCH_PERF_CNT_EN adds saturating wait/drop
// counters. Without it, both perf ports are tied to zero.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | pc_q is the next fetch address; may issue when buffer frees up
// REQ   | request to req_addr_q outstanding, buffer empty
// DROP  | redirected request outstanding, its data will be thrown away
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] INST_NOP = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        hazard_i,
   input  logic        flush_i,
   input  logic [31:0] flush_pc_i,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_data_i,
   output logic [31:0] pc_o,
   output logic [31:0] inst_o,
   output logic        valid_o,
   output logic [31:0] perf_wait_cnt_o,
   output logic [31:0] perf_drop_cnt_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DROP = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] req_addr_q, req_addr_d;
   logic        buf_valid_q, buf_valid_d;
   logic [31:0] buf_pc_q, buf_pc_d;
   logic [31:0] buf_inst_q, buf_inst_d;
   logic        consume;

   assign consume = buf_valid_q & ~hazard_i;

   // Memory request: IDLE issues only when the buffer is empty or drains this cycle
   always_comb begin
      mem_req_o  = 1'b0;
      mem_addr_o = req_addr_q;
      case (state_q)
         ST_IDLE: begin
            mem_req_o  = ~buf_valid_q | consume;
            mem_addr_o = pc_q;
         end
         ST_REQ, ST_DROP: begin
            mem_req_o  = 1'b1;
            mem_addr_o = req_addr_q;
         end
         default: begin
            mem_req_o  = 1'b0;
            mem_addr_o = req_addr_q;
         end
      endcase
   end

   // Next-state, fetch PC and buffer update; flush overrides hazard and ack data
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      req_addr_d  = req_addr_q;
      buf_valid_d = buf_valid_q;
      buf_pc_d    = buf_pc_q;
      buf_inst_d  = buf_inst_q;
      if (flush_i) begin
         buf_valid_d = 1'b0;
         buf_pc_d    = 32'h0000_0000;
         buf_inst_d  = INST_NOP;
         // Low bits of the target are dropped by masking so every bit is consumed.
         pc_d        = flush_pc_i & 32'hFFFF_FFFC;
         if (mem_req_o && !mem_ack_i) begin
            state_d    = ST_DROP;
            req_addr_d = mem_addr_o;
         end else begin
            state_d = ST_IDLE;
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (mem_req_o) begin
                  if (mem_ack_i) begin
                     buf_valid_d = 1'b1;
                     buf_pc_d    = pc_q;
                     buf_inst_d  = mem_data_i;
                     pc_d        = pc_q + 32'd4;
                  end else begin
                     state_d     = ST_REQ;
                     req_addr_d  = pc_q;
                     buf_valid_d = 1'b0;
                     buf_pc_d    = 32'h0000_0000;
                     buf_inst_d  = INST_NOP;
                  end
               end
            end
            ST_REQ: begin
               if (mem_ack_i) begin
                  state_d     = ST_IDLE;
                  buf_valid_d = 1'b1;
                  buf_pc_d    = req_addr_q;
                  buf_inst_d  = mem_data_i;
                  pc_d        = req_addr_q + 32'd4;
               end
            end
            ST_DROP: begin
               if (mem_ack_i) begin
                  state_d = ST_IDLE;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State and datapath registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         pc_q        <= RESET_PC;
         req_addr_q  <= RESET_PC;
         buf_valid_q <= 1'b0;
         buf_pc_q    <= 32'h0000_0000;
         buf_inst_q  <= INST_NOP;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         req_addr_q  <= req_addr_d;
         buf_valid_q <= buf_valid_d;
         buf_pc_q    <= buf_pc_d;
         buf_inst_q  <= buf_inst_d;
      end
   end

   assign valid_o = buf_valid_q;
   assign pc_o    = buf_pc_q;
   assign inst_o  = buf_inst_q;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] wait_cnt_q, wait_cnt_d;
   logic [31:0] drop_cnt_q, drop_cnt_d;
   logic        drop_ack;

   assign drop_ack = mem_ack_i & (flush_i | (state_q == ST_DROP));

   // Saturating counters: request cycles without ack, and discarded acks
   always_comb begin
      wait_cnt_d = wait_cnt_q;
      drop_cnt_d = drop_cnt_q;
      if (mem_req_o && !mem_ack_i && (wait_cnt_q != 32'hFFFF_FFFF)) begin
         wait_cnt_d = wait_cnt_q + 32'd1;
      end
      if (drop_ack && (drop_cnt_q != 32'hFFFF_FFFF)) begin
         drop_cnt_d = drop_cnt_q + 32'd1;
      end
   end

   // Counter registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wait_cnt_q <= 32'h0000_0000;
         drop_cnt_q <= 32'h0000_0000;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign perf_wait_cnt_o = wait_cnt_q;
   assign perf_drop_cnt_o = drop_cnt_q;
`else
   assign perf_wait_cnt_o = 32'h0000_0000;
   assign perf_drop_cnt_o = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Testbench for if_fetch_unit: directed scenarios with literal expectations,
// then randomized hazard/flush/reset/latency traffic checked every cycle
// against a behavioural model of the fetch buffer and memory handshake.
module tb_if_fetch_unit;

   localparam logic [31:0] RPC = 32'h0000_0100;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        hazard_i = 1'b0;
   logic        flush_i = 1'b0;
   logic [31:0] flush_pc_i = 32'h0;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_ack_i = 1'b0;
   logic [31:0] mem_data_i = 32'h0;
   logic [31:0] pc_o;
   logic [31:0] inst_o;
   logic        valid_o;
   logic [31:0] perf_wait_cnt_o;
   logic [31:0] perf_drop_cnt_o;

   if_fetch_unit #(.RESET_PC(RPC), .INST_NOP(NOP)) dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .hazard_i        (hazard_i),
      .flush_i         (flush_i),
      .flush_pc_i      (flush_pc_i),
      .mem_req_o       (mem_req_o),
      .mem_addr_o      (mem_addr_o),
      .mem_ack_i       (mem_ack_i),
      .mem_data_i      (mem_data_i),
      .pc_o            (pc_o),
      .inst_o          (inst_o),
      .valid_o         (valid_o),
      .perf_wait_cnt_o (perf_wait_cnt_o),
      .perf_drop_cnt_o (perf_drop_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   int errors = 0;
   int checks = 0;

   // behavioural model: buffer contents, next fetch PC, outstanding request
   logic        m_init = 1'b0;
   logic        m_valid;
   logic [31:0] m_pc, m_inst, m_fetch, m_paddr;
   logic        m_pend, m_disc;
   logic [31:0] m_wait, m_drop;

   // memory model
   logic        mem_busy = 1'b0;
   int          mem_lat = 0;

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_perf(input string name, input logic [31:0] act, input logic [31:0] exp);
`ifdef FETCH_PERF_CNT_EN
      chk(name, act, exp);
`else
      chk(name, act, 32'h0);
`endif
   endtask

   // One clock cycle: drive inputs, answer memory, compare against model, advance model
   task automatic step(input logic haz, input logic fl, input logic [31:0] fpc,
                       input logic rst, input int lat);
      logic        e_req;
      logic [31:0] e_addr;
      logic        a;
      @(negedge clk_i);
      hazard_i   = haz;
      flush_i    = fl;
      flush_pc_i = fpc;
      rst_i      = rst;
      #1;
      mem_ack_i  = 1'b0;
      mem_data_i = $urandom;
      if (!rst && mem_req_o) begin
         if (!mem_busy) begin
            mem_busy = 1'b1;
            mem_lat  = lat;
         end
         if (mem_lat == 0) begin
            mem_ack_i  = 1'b1;
            mem_data_i = inst_of(mem_addr_o);
         end else begin
            mem_lat--;
         end
      end
      #1;
      e_req  = m_pend | ~m_valid | ~haz;
      e_addr = m_pend ? m_paddr : m_fetch;
      if (m_init) begin
         chk("valid_o", {31'h0, valid_o}, {31'h0, m_valid});
         chk("pc_o", pc_o, m_pc);
         chk("inst_o", inst_o, m_inst);
         chk_perf("perf_wait", perf_wait_cnt_o, m_wait);
         chk_perf("perf_drop", perf_drop_cnt_o, m_drop);
         if (!rst) begin
            chk("mem_req_o", {31'h0, mem_req_o}, {31'h0, e_req});
            if (e_req) chk("mem_addr_o", mem_addr_o, e_addr);
         end
      end
      a = mem_ack_i;
      @(posedge clk_i);
      if (a || rst) mem_busy = 1'b0;
      if (rst) begin
         m_init  = 1'b1;
         m_valid = 1'b0;
         m_pc    = 32'h0;
         m_inst  = NOP;
         m_fetch = RPC;
         m_pend  = 1'b0;
         m_disc  = 1'b0;
         m_paddr = RPC;
         m_wait  = 32'h0;
         m_drop  = 32'h0;
      end else if (m_init) begin
         if (e_req && !a) m_wait = sat_inc(m_wait);
         if (fl) begin
            if (a) m_drop = sat_inc(m_drop);
            m_valid = 1'b0;
            m_pc    = 32'h0;
            m_inst  = NOP;
            m_fetch = {fpc[31:2], 2'b00};
            if (e_req && !a) begin
               m_pend  = 1'b1;
               m_disc  = 1'b1;
               m_paddr = e_addr;
            end else begin
               m_pend = 1'b0;
               m_disc = 1'b0;
            end
         end else if (a) begin
            if (m_disc) begin
               m_drop = sat_inc(m_drop);
            end else begin
               m_valid = 1'b1;
               m_pc    = e_addr;
               m_inst  = inst_of(e_addr);
               m_fetch = e_addr + 32'd4;
            end
            m_pend = 1'b0;
            m_disc = 1'b0;
         end else if (e_req) begin
            if (!m_pend) begin
               m_pend  = 1'b1;
               m_paddr = e_addr;
            end
            m_valid = 1'b0;
            m_pc    = 32'h0;
            m_inst  = NOP;
         end
      end
   endtask

   initial begin
      int r;
      int lat;
      logic [31:0] fpc;

      // reset values
      step(0, 0, 32'h0, 1, 0);
      step(0, 0, 32'h0, 1, 0);
      #1;
      chk("rst valid", {31'h0, valid_o}, 32'h0);
      chk("rst pc", pc_o, 32'h0);
      chk("rst inst", inst_o, NOP);
      chk("rst addr", mem_addr_o, 32'h100);

      // zero-wait streaming
      step(0, 0, 32'h0, 0, 0); #1;
      chk("zw pc0", pc_o, 32'h100);
      chk("zw valid0", {31'h0, valid_o}, 32'h1);
      chk("zw inst0", inst_o, inst_of(32'h100));
      step(0, 0, 32'h0, 0, 0); #1;
      chk("zw pc1", pc_o, 32'h104);
      step(0, 0, 32'h0, 0, 0); #1;
      chk("zw pc2", pc_o, 32'h108);

      // three-cycle memory wait on 0x104
      step(0, 0, 32'h0, 1, 0);
      step(0, 0, 32'h0, 0, 0); #1;
      chk("w pc0", pc_o, 32'h100);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 32'h0, 0, (i == 0) ? 3 : 0); #1;
         chk("w valid", {31'h0, valid_o}, 32'h0);
         chk("w inst", inst_o, NOP);
         chk("w req", {31'h0, mem_req_o}, 32'h1);
         chk("w addr", mem_addr_o, 32'h104);
      end
      step(0, 0, 32'h0, 0, 0); #1;
      chk("w pc1", pc_o, 32'h104);
      chk_perf("w perf_wait", perf_wait_cnt_o, 32'd3);

      // two-cycle hazard stall
      for (int i = 0; i < 2; i++) begin
         step(1, 0, 32'h0, 0, 0); #1;
         chk("hz req", {31'h0, mem_req_o}, 32'h0);
         chk("hz pc", pc_o, 32'h104);
         chk("hz valid", {31'h0, valid_o}, 32'h1);
         chk("hz inst", inst_o, inst_of(32'h104));
      end
      step(0, 0, 32'h0, 0, 0); #1;
      chk("hz resume", pc_o, 32'h108);

      // flush to 0x203 while in REQ, ack two cycles later
      step(0, 0, 32'h0, 0, 3);
      step(0, 1, 32'h203, 0, 0); #1;
      chk("fl valid", {31'h0, valid_o}, 32'h0);
      step(0, 0, 32'h0, 0, 0);
      step(0, 0, 32'h0, 0, 0); #1;
      chk("fl valid2", {31'h0, valid_o}, 32'h0);
      chk_perf("fl drop", perf_drop_cnt_o, 32'd1);
      chk("fl req", {31'h0, mem_req_o}, 32'h1);
      chk("fl addr", mem_addr_o, 32'h200);
      step(0, 0, 32'h0, 0, 0); #1;
      chk("fl pc", pc_o, 32'h200);
      chk("fl inst", inst_o, inst_of(32'h200));

      // flush with ack and hazard in the same cycle
      step(0, 0, 32'h0, 0, 1);
      step(1, 1, 32'h300, 0, 0); #1;
      chk("fa valid", {31'h0, valid_o}, 32'h0);
      chk("fa req", {31'h0, mem_req_o}, 32'h1);
      chk("fa addr", mem_addr_o, 32'h300);
      chk_perf("fa drop", perf_drop_cnt_o, 32'd2);

      // redirect to the top word and wrap
      step(0, 1, 32'hFFFF_FFFF, 0, 0); #1;
      chk("wr addr", mem_addr_o, 32'hFFFF_FFFC);
      step(0, 0, 32'h0, 0, 0); #1;
      chk("wr pc", pc_o, 32'hFFFF_FFFC);
      chk("wr next", mem_addr_o, 32'h0);
      step(0, 0, 32'h0, 0, 0); #1;
      chk("wr pc0", pc_o, 32'h0);

      // reset in the middle of an outstanding request
      step(0, 0, 32'h0, 0, 5);
      step(0, 0, 32'h0, 0, 0);
      step(0, 0, 32'h0, 1, 0); #1;
      chk("mr valid", {31'h0, valid_o}, 32'h0);
      chk("mr pc", pc_o, 32'h0);
      chk("mr inst", inst_o, NOP);
      chk("mr addr", mem_addr_o, 32'h100);
      chk("mr wait", perf_wait_cnt_o, 32'h0);
      chk("mr drop", perf_drop_cnt_o, 32'h0);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         r   = $urandom_range(0, 9);
         lat = (r < 5) ? 0 : r - 5;
         fpc = $urandom;
         if ($urandom_range(0, 7) == 0) fpc = {30'h3FFF_FFFF, fpc[1:0]};
         step($urandom_range(0, 99) < 30,
              $urandom_range(0, 99) < 8,
              fpc,
              $urandom_range(0, 199) == 0,
              lat);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
